obj_line_scanner: RTL and testbench

- Read-side consumer of the object RAM that the game controller writes.
- For each scanline, it scans every object entry during horizontal blanking and keeps up to MAX_PER_LINE objects whose tile row matches the upcoming line.
- During active video it reports, per pixel, whether an object tile covers that pixel, plus the tile number and the in-tile pixel offsets for the sprite ROM lookup.
- It sits between the object RAM read port and the pixel mixer, alongside the background renderer.

---
 rtl/obj_line_scanner.sv | 153 +++++++++++++++
 tb/tb_obj_line_scanner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_line_scanner.sv
// Object line scanner: gathers the objects on the upcoming tile row from object RAM
// during horizontal blanking, then reports per-pixel object coverage for the sprite ROM.
`timescale 1ns/1ps
module obj_line_scanner #(
    parameter int NUM_OBJ      = 16,
    parameter int MAX_PER_LINE = 4,
    parameter int TILE_SHIFT   = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  iHS,
    input  logic                  iDE,
    input  logic [9:0]            iX,
    input  logic [9:0]            iY,
    input  logic [9:0]            iNextY,
    output logic [3:0]            oObjRam_addr,
    input  logic [12:0]           iObjRam_data,
    output logic                  oHit,
    output logic [2:0]            oTile,
    output logic [TILE_SHIFT-1:0] oOffX,
    output logic [TILE_SHIFT-1:0] oOffY,
    output logic                  oOverflow
);
    localparam int         CNT_W     = $clog2(MAX_PER_LINE + 1);
    localparam logic [3:0] LAST_ADDR = 4'(NUM_OBJ - 1);

    typedef enum logic [1:0] {IDLE, SCAN, LAST, SWAP} state_t;
    state_t state, stateNext;

    logic             lastHS;
    logic             lineSyn;
    logic [3:0]       addrNext;
    logic             startScan;
    logic             captureEn;
    logic             swapEn;
    logic [3:0]       scanRow;
    logic [CNT_W-1:0] shCount;
    logic [CNT_W-1:0] acCount;
    logic             ovfFlag;
    logic             objMatch;
    logic [2:0]       shTile [MAX_PER_LINE];
    logic [4:0]       shX    [MAX_PER_LINE];
    logic [2:0]       acTile [MAX_PER_LINE];
    logic [4:0]       acX    [MAX_PER_LINE];
    logic             hitAny;
    logic [2:0]       hitTile;
    logic             unusedBits;

    assign lineSyn    = lastHS & ~iHS;
    assign objMatch   = captureEn & iObjRam_data[12] & (iObjRam_data[3:0] == scanRow);
    assign unusedBits = ^{iY[9:TILE_SHIFT], iNextY[9:TILE_SHIFT+4], iNextY[TILE_SHIFT-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    // A new line start always wins: it restarts the scan and suppresses any pending swap.
    always_comb begin
        stateNext = state;
        addrNext  = oObjRam_addr;
        startScan = 1'b0;
        captureEn = 1'b0;
        swapEn    = 1'b0;
        if (lineSyn) begin
            startScan = 1'b1;
            addrNext  = 4'd0;
            stateNext = SCAN;
        end else begin
            case (state)
                SCAN: begin
                    captureEn = (oObjRam_addr != 4'd0);
                    if (oObjRam_addr == LAST_ADDR) stateNext = LAST;
                    else                           addrNext  = oObjRam_addr + 4'd1;
                end
                LAST: begin
                    captureEn = 1'b1;
                    stateNext = SWAP;
                end
                SWAP: begin
                    swapEn    = 1'b1;
                    stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lastHS       <= 1'b0;
            oObjRam_addr <= 4'd0;
            shCount      <= '0;
            acCount      <= '0;
            ovfFlag      <= 1'b0;
            oOverflow    <= 1'b0;
        end else begin
            lastHS       <= iHS;
            oObjRam_addr <= addrNext;
            oOverflow    <= swapEn & ovfFlag;
            if (startScan) begin
                shCount <= '0;
                ovfFlag <= 1'b0;
            end else if (objMatch) begin
                if (shCount < CNT_W'(MAX_PER_LINE)) shCount <= shCount + CNT_W'(1);
                else                                ovfFlag <= 1'b1;
            end
            if (swapEn) acCount <= shCount;
        end
    end

    // Entry storage: shadow fills in RAM address order, active is replaced only at swap.
    always_ff @(posedge clk) begin
        if (startScan) scanRow <= iNextY[TILE_SHIFT+3:TILE_SHIFT];
        for (int i = 0; i < MAX_PER_LINE; i++) begin
            if (objMatch && shCount == CNT_W'(i)) begin
                shTile[i] <= iObjRam_data[11:9];
                shX[i]    <= iObjRam_data[8:4];
            end
            if (swapEn) begin
                acTile[i] <= shTile[i];
                acX[i]    <= shX[i];
            end
        end
    end

    // Walk from the top index down so the lowest-index (lowest-address) hit is the one kept.
    always_comb begin
        hitAny  = 1'b0;
        hitTile = 3'd0;
        for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
            if (CNT_W'(i) < acCount && acX[i] == iX[TILE_SHIFT+4:TILE_SHIFT]) begin
                hitAny  = 1'b1;
                hitTile = acTile[i];
            end
        end
    end

    // Pixel stage boundary: one register between pixel coordinates and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oHit  <= 1'b0;
            oTile <= 3'd0;
            oOffX <= '0;
            oOffY <= '0;
        end else begin
            oHit  <= iDE & hitAny;
            oTile <= (iDE & hitAny) ? hitTile : 3'd0;
            oOffX <= iX[TILE_SHIFT-1:0];
            oOffY <= iY[TILE_SHIFT-1:0];
        end
    end
endmodule

// File: tb/tb_obj_line_scanner.sv
// Bench for obj_line_scanner: directed scenarios with literal expectations plus
// randomized lines, all checked each cycle against a line-level behavioural model.
`timescale 1ns/1ps
module tb_obj_line_scanner;
    localparam int NUM_OBJ      = 16;
    localparam int MAX_PER_LINE = 4;
    localparam int TILE_SHIFT   = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        iHS = 1'b0;
    logic        iDE = 1'b0;
    logic [9:0]  iX = '0;
    logic [9:0]  iY = '0;
    logic [9:0]  iNextY = '0;
    logic [3:0]  oObjRam_addr;
    logic [12:0] iObjRam_data;
    logic        oHit;
    logic [2:0]  oTile;
    logic [4:0]  oOffX;
    logic [4:0]  oOffY;
    logic        oOverflow;

    logic [12:0] ram [NUM_OBJ];
    int tests = 0;
    int fails = 0;

    obj_line_scanner #(.NUM_OBJ(NUM_OBJ), .MAX_PER_LINE(MAX_PER_LINE), .TILE_SHIFT(TILE_SHIFT)) dut (
        .clk(clk), .reset_n(reset_n), .iHS(iHS), .iDE(iDE), .iX(iX), .iY(iY), .iNextY(iNextY),
        .oObjRam_addr(oObjRam_addr), .iObjRam_data(iObjRam_data), .oHit(oHit), .oTile(oTile),
        .oOffX(oOffX), .oOffY(oOffY), .oOverflow(oOverflow)
    );

    always #5 clk = ~clk;

    // Object RAM with one cycle of read latency.
    always @(posedge clk) iObjRam_data <= ram[oObjRam_addr];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         mCnt = 0;
    logic [2:0] mTile [MAX_PER_LINE];
    logic [4:0] mX    [MAX_PER_LINE];
    int         cd = 0;
    logic [3:0] pendRow = '0;
    logic       mLastHS = 1'b0;
    logic       eHit = 1'b0, eOvf = 1'b0;
    logic [2:0] eTile = '0;
    logic [4:0] eOffX = '0, eOffY = '0;
    logic [3:0] eAddr = '0;

    // The objects of a row, in ascending address order, capped at the buffer size.
    task automatic buildLine(input logic [3:0] row, output logic ovf);
        ovf = 1'b0;
        mCnt = 0;
        for (int a = 0; a < NUM_OBJ; a++) begin
            if (ram[a][12] && ram[a][3:0] == row) begin
                if (mCnt < MAX_PER_LINE) begin
                    mTile[mCnt] = ram[a][11:9];
                    mX[mCnt]    = ram[a][8:4];
                    mCnt++;
                end else begin
                    ovf = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            mCnt = 0; cd = 0; mLastHS = 1'b0;
            eHit = 1'b0; eTile = '0; eOffX = '0; eOffY = '0; eOvf = 1'b0; eAddr = '0;
        end else begin
            eHit = 1'b0; eTile = '0;
            if (iDE)
                for (int i = 0; i < mCnt; i++)
                    if (!eHit && mX[i] == iX[9:5]) begin eHit = 1'b1; eTile = mTile[i]; end
            eOffX = iX[4:0];
            eOffY = iY[4:0];
            eOvf  = 1'b0;
            if (mLastHS && !iHS) begin
                cd = NUM_OBJ + 2;
                pendRow = iNextY[TILE_SHIFT+3:TILE_SHIFT];
                eAddr = '0;
            end else if (cd > 0) begin
                cd--;
                if (eAddr < 4'(NUM_OBJ - 1)) eAddr++;
                if (cd == 0) buildLine(pendRow, eOvf);
            end
            mLastHS = iHS;
        end
    end

    always @(posedge clk) begin
        #1;
        check("oHit", oHit, eHit);
        check("oTile", oTile, eTile);
        check("oOffX", oOffX, eOffX);
        check("oOffY", oOffY, eOffY);
        check("oOverflow", oOverflow, eOvf);
        check("oObjRam_addr", oObjRam_addr, eAddr);
    end

    // ---------------- stimulus helpers ----------------
    task automatic startLine(input logic [9:0] ny);
        @(negedge clk); iHS = 1'b1;
        @(negedge clk);
        @(negedge clk); iNextY = ny; iHS = 1'b0;
    endtask

    task automatic runLine(input logic [9:0] ny, input int abortAt, input logic [9:0] ny2,
                           input bit rnd, output int ovCnt, output int addrBad, output int hitCyc);
        int len;
        int expA;
        startLine(ny);
        len = (abortAt >= 0) ? abortAt + 24 : 22;
        ovCnt = 0; addrBad = 0; hitCyc = 0;
        for (int j = 0; j < len; j++) begin
            @(posedge clk); #2;
            expA = (abortAt >= 0 && j >= abortAt + 2) ? j - abortAt - 2 : j;
            if (expA > NUM_OBJ - 1) expA = NUM_OBJ - 1;
            if (int'(oObjRam_addr) != expA) addrBad++;
            if (oOverflow) ovCnt++;
            if (oHit) hitCyc++;
            if (rnd) begin
                iDE = 1'($urandom_range(0, 1));
                iX  = 10'($urandom_range(0, 639));
                iY  = 10'($urandom_range(0, 479));
            end
            if (j == abortAt) iHS = 1'b1;
            if (abortAt >= 0 && j == abortAt + 1) begin iHS = 1'b0; iNextY = ny2; end
        end
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic de);
        @(negedge clk); iX = x; iY = y; iDE = de;
        @(posedge clk); #2;
    endtask

    task automatic clearRam();
        for (int a = 0; a < NUM_OBJ; a++) ram[a] = '0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_hit"}, oHit, 0);
        check({tag, "_tile"}, oTile, 0);
        check({tag, "_offx"}, oOffX, 0);
        check({tag, "_offy"}, oOffY, 0);
        check({tag, "_ovf"}, oOverflow, 0);
        check({tag, "_addr"}, oObjRam_addr, 0);
    endtask

    initial begin
        int ov, ab, hc, cnt, bias, abortAt;
        logic [9:0] ny, ny2;
        logic [3:0] row;
        logic [12:0] w;
        clearRam();
        repeat (3) @(negedge clk);
        iX = 10'd77; iY = 10'd45;
        #1 checkAllZero("reset");
        @(negedge clk); reset_n = 1'b1;

        // Single object on row 1, X tile 2.
        ram[0] = 13'h1021;
        runLine(10'd32, -1, 10'd0, 1'b0, ov, ab, hc);
        check("single_addrSeq", ab, 0);
        check("single_ovf", ov, 0);
        for (int x = 64; x <= 96; x++) begin
            pix(10'(x), 10'd32, 1'b1);
            check("single_hit", oHit, (x < 96) ? 1 : 0);
            if (x < 96) begin
                check("single_tile", oTile, 0);
                check("single_offx", oOffX, x - 64);
            end
        end

        // Overlap: lowest address wins.
        clearRam();
        ram[0] = 13'h1032;
        ram[5] = 13'h1232;
        runLine(10'd70, -1, 10'd0, 1'b0, ov, ab, hc);
        pix(10'd100, 10'd70, 1'b1);
        check("overlap_hit", oHit, 1);
        check("overlap_tile", oTile, 0);
        check("overlap_offy", oOffY, 6);
        check("overlap_offx", oOffX, 4);
        ram[0] = 13'h0032;
        runLine(10'd70, -1, 10'd0, 1'b0, ov, ab, hc);
        pix(10'd100, 10'd70, 1'b1);
        check("overlap2_hit", oHit, 1);
        check("overlap2_tile", oTile, 1);

        // Overflow: five objects on row 4, only the first four kept.
        clearRam();
        for (int t = 0; t < 5; t++) ram[t] = 13'h1000 | 13'(t << 9) | 13'((t + 1) << 4) | 13'd4;
        runLine(10'd128, -1, 10'd0, 1'b0, ov, ab, hc);
        check("ovf_pulses", ov, 1);
        check("ovf_addrSeq", ab, 0);
        for (int x = 1; x <= 5; x++) begin
            pix(10'(x * 32 + 7), 10'd128, 1'b1);
            check("ovf_hit", oHit, (x <= 4) ? 1 : 0);
            check("ovf_tile", oTile, (x <= 4) ? x - 1 : 0);
        end

        // Old buffer holds until the swap of a scan that finds nothing.
        iX = 10'd32; iY = 10'd0; iDE = 1'b1;
        runLine(10'd0, -1, 10'd0, 1'b0, ov, ab, hc);
        check("hold_hitCycles", hc, 19);
        check("hold_ovf", ov, 0);

        // Abort: restart 8 cycles into a scan with a different row.
        clearRam();
        ram[0] = 13'h1021;
        ram[1] = 13'h1463;
        runLine(10'd32, -1, 10'd0, 1'b0, ov, ab, hc);
        iX = 10'd64; iY = 10'd0; iDE = 1'b1;
        runLine(10'd0, 6, 10'd96, 1'b0, ov, ab, hc);
        check("abort_hitCycles", hc, 27);
        check("abort_addrSeq", ab, 0);
        check("abort_ovf", ov, 0);
        pix(10'd64, 10'd96, 1'b1);
        check("abort_oldX", oHit, 0);
        pix(10'd192, 10'd96, 1'b1);
        check("abort_newHit", oHit, 1);
        check("abort_newTile", oTile, 2);

        // Reset in the middle of a scan.
        startLine(10'd96);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 checkAllZero("midreset");
        @(negedge clk); @(negedge clk); reset_n = 1'b1;
        cnt = 0;
        for (int j = 0; j < 25; j++) begin
            @(posedge clk); #2;
            if (oHit) cnt++;
        end
        check("reset_noHit", cnt, 0);
        runLine(10'd96, -1, 10'd0, 1'b0, ov, ab, hc);
        check("reset_rescanHit", hc, 3);

        // Randomized lines.
        for (int n = 0; n < 40; n++) begin
            ny = 10'($urandom_range(0, 479));
            row = ny[8:5];
            bias = $urandom_range(1, 10);
            for (int a = 0; a < NUM_OBJ; a++) begin
                w = '0;
                w[12]   = ($urandom_range(0, 3) != 0);
                w[11:9] = 3'($urandom);
                w[8:4]  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
                w[3:0]  = ($urandom_range(0, 15) < bias) ? row : 4'($urandom);
                ram[a] = w;
            end
            abortAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            ny2 = 10'($urandom_range(0, 479));
            runLine(ny, abortAt, ny2, 1'b1, ov, ab, hc);
            check("rand_addrSeq", ab, 0);
            for (int p = 0; p < 24; p++)
                pix(10'($urandom_range(0, 639)), ny, ($urandom_range(0, 7) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
